// File: rtl/memory_cycle_pkg.sv
// rtl/memory_cycle_pkg.sv - shared encodings for the memory stage
package memory_cycle_pkg;
    localparam int XLEN = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
endpackage

// File: rtl/memory_cycle_data_memory.sv
// rtl/memory_cycle_data_memory.sv - word array, byte-enable sync write, async read
module memory_cycle_data_memory
    import memory_cycle_pkg::*;
#(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    input  logic              we,
    input  logic [3:0]        be,
    input  logic [XLEN-1:0]   wdata,
    output logic [XLEN-1:0]   rdata
);
    logic [XLEN-1:0] mem [DEPTH];

    // Contents are deliberately left unreset; only the pipeline register clears.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[addr];
endmodule

// File: rtl/memory_cycle.sv
// rtl/memory_cycle.sv - RISC-V memory stage with M/W pipeline register
module memory_cycle
    import memory_cycle_pkg::*;
#(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            RegWriteM,
    input  logic            MemWriteM,
    input  logic            ResultSrcM,
    input  logic [2:0]      funct3M,
    input  logic [4:0]      RDM,
    input  logic [XLEN-1:0] ALU_ResultM,
    input  logic [XLEN-1:0] WriteDataM,
    input  logic [XLEN-1:0] PCPlus4M,
    output logic            RegWriteW,
    output logic            ResultSrcW,
    output logic [4:0]      RDW,
    output logic [XLEN-1:0] ALU_ResultW,
    output logic [XLEN-1:0] ReadDataW,
    output logic [XLEN-1:0] PCPlus4W,
    output logic            MisalignW
);
    logic [XLEN-1:0] rdata;
    logic [XLEN-1:0] wdata;
    logic [XLEN-1:0] load_data;
    logic [3:0]      be;
    logic            mis_raw;
    logic            misalign;
    logic            we;
    logic [7:0]      byte_v;
    logic [15:0]     half_v;

    assign byte_v = rdata[{ALU_ResultM[1:0], 3'b000} +: 8];
    assign half_v = rdata[{ALU_ResultM[1], 4'b0000} +: 16];

    // Byte enables are only produced for store encodings, so LBU/LHU with
    // MemWriteM never reach the array.
    always_comb begin
        mis_raw   = 1'b0;
        be        = 4'b0000;
        wdata     = WriteDataM;
        load_data = '0;
        case (funct3M)
            F3_B: begin
                be        = 4'b0001 << ALU_ResultM[1:0];
                wdata     = {4{WriteDataM[7:0]}};
                load_data = {{24{byte_v[7]}}, byte_v};
            end
            F3_BU: load_data = {24'd0, byte_v};
            F3_H: begin
                mis_raw   = ALU_ResultM[0];
                be        = ALU_ResultM[1] ? 4'b1100 : 4'b0011;
                wdata     = {2{WriteDataM[15:0]}};
                load_data = {{16{half_v[15]}}, half_v};
            end
            F3_HU: begin
                mis_raw   = ALU_ResultM[0];
                load_data = {16'd0, half_v};
            end
            F3_W: begin
                mis_raw   = |ALU_ResultM[1:0];
                be        = 4'b1111;
                load_data = rdata;
            end
            default: mis_raw = 1'b1;
        endcase
    end

    // Alignment only matters when the instruction actually touches memory.
    assign misalign = (MemWriteM | ResultSrcM) & mis_raw;
    assign we       = MemWriteM & rst & ~misalign;

    memory_cycle_data_memory #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_dmem (
        .clk   (clk),
        .addr  (ALU_ResultM[ADDR_W+1:2]),
        .we    (we),
        .be    (be),
        .wdata (wdata),
        .rdata (rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            RegWriteW   <= 1'b0;
            ResultSrcW  <= 1'b0;
            RDW         <= '0;
            ALU_ResultW <= '0;
            ReadDataW   <= '0;
            PCPlus4W    <= '0;
            MisalignW   <= 1'b0;
        end else begin
            RegWriteW   <= RegWriteM & ~(misalign & ResultSrcM);
            ResultSrcW  <= ResultSrcM;
            RDW         <= RDM;
            ALU_ResultW <= ALU_ResultM;
            ReadDataW   <= load_data;
            PCPlus4W    <= PCPlus4M;
            MisalignW   <= misalign;
        end
    end
endmodule

// File: tb/tb_memory_cycle.sv
// tb/tb_memory_cycle.sv - self-checking bench for memory_cycle
module tb_memory_cycle;
    localparam int DEPTH = 1024;
    localparam int NBYTES = DEPTH * 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        RegWriteM = 1'b0, MemWriteM = 1'b0, ResultSrcM = 1'b0;
    logic [2:0]  funct3M = 3'd0;
    logic [4:0]  RDM = 5'd0;
    logic [31:0] ALU_ResultM = '0, WriteDataM = '0, PCPlus4M = '0;
    logic        RegWriteW, ResultSrcW, MisalignW;
    logic [4:0]  RDW;
    logic [31:0] ALU_ResultW, ReadDataW, PCPlus4W;

    int tests = 0;
    int fails = 0;

    memory_cycle dut (
        .clk         (clk),
        .rst         (rst),
        .RegWriteM   (RegWriteM),
        .MemWriteM   (MemWriteM),
        .ResultSrcM  (ResultSrcM),
        .funct3M     (funct3M),
        .RDM         (RDM),
        .ALU_ResultM (ALU_ResultM),
        .WriteDataM  (WriteDataM),
        .PCPlus4M    (PCPlus4M),
        .RegWriteW   (RegWriteW),
        .ResultSrcW  (ResultSrcW),
        .RDW         (RDW),
        .ALU_ResultW (ALU_ResultW),
        .ReadDataW   (ReadDataW),
        .PCPlus4W    (PCPlus4W),
        .MisalignW   (MisalignW)
    );

    always #5 clk = ~clk;

    // Byte-addressed reference memory; vld marks bytes the bench has written.
    logic [7:0]  mb  [NBYTES];
    bit          vld [NBYTES];

    bit          exp_valid = 0;
    bit          e_rd_known;
    logic        e_regw, e_rsrc, e_mis;
    logic [4:0]  e_rd;
    logic [31:0] e_alu, e_rdata, e_pc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int     a, n, base;
        bit     undef, mis, known, sgn;
        longint v;
        if (!rst) begin
            {e_regw, e_rsrc, e_mis} = 3'b000;
            e_rd = '0; e_alu = '0; e_rdata = '0; e_pc = '0;
            e_rd_known = 1;
        end else begin
            case (funct3M)
                3'd0, 3'd4: n = 1;
                3'd1, 3'd5: n = 2;
                3'd2:       n = 4;
                default:    n = 0;
            endcase
            undef = (n == 0);
            a     = int'(ALU_ResultM % NBYTES);
            mis   = (MemWriteM || ResultSrcM) && (undef ? 1'b1 : ((a % n) != 0));
            sgn   = (funct3M == 3'd0) || (funct3M == 3'd1);
            v     = 0;
            known = 1;
            if (!undef) begin
                base = a - (a % n);
                for (int k = 0; k < n; k++) begin
                    v = v | (longint'(mb[base + k]) << (8 * k));
                    if (!vld[base + k]) known = 0;
                end
                if (sgn && v[8*n-1]) v = v - (64'sd1 << (8 * n));
            end
            e_regw     = RegWriteM && !(mis && ResultSrcM);
            e_rsrc     = ResultSrcM;
            e_rd       = RDM;
            e_alu      = ALU_ResultM;
            e_pc       = PCPlus4M;
            e_mis      = mis;
            e_rdata    = v[31:0];
            e_rd_known = known;
            if (MemWriteM && !mis && funct3M <= 3'd2) begin
                for (int k = 0; k < n; k++) begin
                    mb[a + k]  = WriteDataM[8*k +: 8];
                    vld[a + k] = 1;
                end
            end
        end
        exp_valid = 1;
    endtask

    always @(posedge clk) model_step();

    always @(negedge clk) begin
        if (exp_valid) begin
            chk("RegWriteW",   {31'd0, RegWriteW},  {31'd0, e_regw});
            chk("ResultSrcW",  {31'd0, ResultSrcW}, {31'd0, e_rsrc});
            chk("MisalignW",   {31'd0, MisalignW},  {31'd0, e_mis});
            chk("RDW",         {27'd0, RDW},        {27'd0, e_rd});
            chk("ALU_ResultW", ALU_ResultW, e_alu);
            chk("PCPlus4W",    PCPlus4W,    e_pc);
            if (e_rd_known) chk("ReadDataW", ReadDataW, e_rdata);
        end
    end

    task automatic step(input logic r, input logic rw, input logic mw, input logic rs,
                        input logic [2:0] f3, input logic [4:0] rd,
                        input logic [31:0] alu, input logic [31:0] wd, input logic [31:0] pc);
        @(negedge clk);
        rst = r; RegWriteM = rw; MemWriteM = mw; ResultSrcM = rs;
        funct3M = f3; RDM = rd; ALU_ResultM = alu; WriteDataM = wd; PCPlus4M = pc;
    endtask

    task automatic st(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        step(1'b1, 1'b0, 1'b1, 1'b0, f3, 5'd0, a, d, 32'h200);
    endtask

    task automatic ld(input logic [2:0] f3, input logic [31:0] a);
        step(1'b1, 1'b1, 1'b0, 1'b1, f3, 5'd3, a, 32'h0, 32'h204);
    endtask

    // Literal check of the W outputs produced by the step just issued.
    task automatic pin(input string name, input logic [31:0] act_sel, input logic [31:0] exp);
        chk(name, act_sel, exp);
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 2; i++)
            step(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom),
                 5'($urandom), $urandom, $urandom, $urandom);
        after_edge();
        pin("reset_rd",  ReadDataW, 32'h0);
        pin("reset_rdw", {27'd0, RDW}, 32'h0);

        st(3'b010, 32'h10, 32'hDEADBEEF);
        ld(3'b010, 32'h10);
        after_edge(); pin("lw_10", ReadDataW, 32'hDEADBEEF);

        st(3'b010, 32'h20, 32'h11223344);
        st(3'b000, 32'h21, 32'h000000AA);
        ld(3'b010, 32'h20);
        after_edge(); pin("lw_20", ReadDataW, 32'h1122AA44);
        ld(3'b000, 32'h21);
        after_edge(); pin("lb_21", ReadDataW, 32'hFFFFFFAA);
        ld(3'b100, 32'h21);
        after_edge(); pin("lbu_21", ReadDataW, 32'h000000AA);

        st(3'b001, 32'h32, 32'h00008001);
        ld(3'b001, 32'h32);
        after_edge(); pin("lh_32", ReadDataW, 32'hFFFF8001);
        ld(3'b101, 32'h32);
        after_edge(); pin("lhu_32", ReadDataW, 32'h00008001);
        ld(3'b010, 32'h30);
        after_edge(); pin("lw_30_hi", {16'd0, ReadDataW[31:16]}, 32'h00008001);

        st(3'b010, 32'h40, 32'h0BADF00D);
        st(3'b010, 32'h41, 32'h12345678);
        after_edge(); pin("sw_41_mis", {31'd0, MisalignW}, 32'd1);
        ld(3'b010, 32'h40);
        after_edge(); pin("lw_40", ReadDataW, 32'h0BADF00D);
        ld(3'b001, 32'h43);
        after_edge();
        pin("lh_43_regw", {31'd0, RegWriteW}, 32'd0);
        pin("lh_43_mis",  {31'd0, MisalignW}, 32'd1);

        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 5'(5 + i), 32'h100 + 32'(i),
                 32'h0, 32'h104 + 32'(4 * i));
        after_edge();
        pin("alu_rdw", {27'd0, RDW}, 32'd7);
        pin("alu_pc",  PCPlus4W, 32'h10C);

        st(3'b010, NBYTES + 32'h8, 32'hCAFEF00D);
        ld(3'b010, 32'h8);
        after_edge(); pin("wrap_lw_8", ReadDataW, 32'hCAFEF00D);
        step(1'b0, 1'b0, 1'b1, 1'b0, 3'b010, 5'd0, 32'h8, 32'h55555555, 32'h0);
        ld(3'b010, 32'h8);
        after_edge(); pin("rst_store_lw_8", ReadDataW, 32'hCAFEF00D);

        step(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 5'd0, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/memory_cycle.md
Name: memory_cycle

Overview:
Memory stage of the 5-stage RISC-V pipeline. It is the producer side of the writeback interface and sits between execute and writeback.
- Performs load/store accesses to an internal data memory.
- Sign- or zero-extends load data.
- Registers all writeback-bound signals (ReadDataW, ALU_ResultW, PCPlus4W, ResultSrcW, RegWriteW, RDW) into the M/W pipeline register.
- The writeback stage's result mux then selects ALU_ResultW or ReadDataW with no further timing.

Parameters:
DEPTH, 1024, number of 32-bit words in data memory (power of 2)
ADDR_W, 10, word-address width, equals log2(DEPTH)

Ports:
clk  input  1  pipeline clock, all state updates on rising edge
rst  input  1  synchronous, active-low reset
RegWriteM  input  1  instruction writes rd
MemWriteM  input  1  instruction is a store
ResultSrcM  input  1  0 = ALU result, 1 = load data
funct3M  input  3  access size/sign: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU
RDM  input  5  destination register
ALU_ResultM  input  32  effective byte address / ALU result
WriteDataM  input  32  store data (rs2)
PCPlus4M  input  32  PC+4
RegWriteW  output  1  registered RegWriteM, forced 0 on misaligned load
ResultSrcW  output  1  registered ResultSrcM
RDW  output  5  registered RDM
ALU_ResultW  output  32  registered ALU_ResultM
ReadDataW  output  32  registered, extended load data
PCPlus4W  output  32  registered PCPlus4M
MisalignW  output  1  registered flag: the access in M was misaligned

Behaviour:
- Reset: on a rising clk edge with rst=0, every W output is cleared to 0. Memory contents are not cleared.
- Latency: exactly one cycle, M inputs to W outputs. There is no stall and no bubble insertion.
- Memory read is combinational from the word index ALU_ResultM[ADDR_W+1:2]. The read result is captured only in the M/W register.
- Address wrap: upper address bits above ADDR_W+1 are ignored, so an address modulo DEPTH*4 aliases.
- Store, when MemWriteM=1, rst=1 and the access is aligned, is a synchronous write on the same edge:
  - SB writes byte lane ALU_ResultM[1:0] with WriteDataM[7:0].
  - SH writes halfword lane ALU_ResultM[1] with WriteDataM[15:0].
  - SW writes the full word.
  - Other lanes are preserved via byte enables.
- Misaligned:
  - A halfword access is misaligned when addr[0]=1.
  - A word access is misaligned when addr[1:0]!=0.
  - A misaligned store is suppressed: memory is unchanged.
  - A misaligned load forces RegWriteW=0.
  - In both cases MisalignW=1 for that cycle.
  - Undefined funct3 with MemWriteM or ResultSrcM set is treated as misaligned.
- Load extension:
  - Byte selected by addr[1:0], halfword by addr[1].
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
  - ReadDataW is computed every cycle regardless of ResultSrcM, except that undefined funct3 yields 0.
- Read-during-write: a load in M reads the memory contents from before the current edge's store. There is never a same-cycle conflict, since only one instruction occupies M.
- Reset mid-operation: a store presented in the same cycle as rst=0 is not performed.
- RDM=0: passed through unchanged. x0 suppression belongs to the register file.

Decomposition:
- Shared package: funct3 load/store encodings (F3_B, F3_H, F3_W, F3_BU, F3_HU) and XLEN=32.
- One natural sub-module, data_memory: DEPTH x 32 array, 4-bit byte-enable synchronous write, combinational read.
- Alignment check, byte-enable generation, load extension and the M/W register stay in memory_cycle.

Test Plan:
- Reset: rst=0 for 2 cycles with random M inputs -> all W outputs 0. Release, then SW 0xDEADBEEF @0x10 -> after the edge, LW @0x10 gives ReadDataW=0xDEADBEEF one cycle later.
- Byte lanes: SW 0x11223344 @0x20, then SB 0xAA @0x21, then LW @0x20 -> 0x1122AA44. Then LB @0x21 -> 0xFFFFFFAA and LBU @0x21 -> 0x000000AA.
- Halfword: SH 0x8001 @0x32, then LH @0x32 -> 0xFFFF8001, LHU @0x32 -> 0x00008001, LW @0x30 -> upper half 0x8001.
- Misaligned: SW 0x12345678 @0x41 -> MisalignW=1, and a later LW @0x40 returns the prior contents. LH @0x43 with RegWriteM=1 -> RegWriteW=0, MisalignW=1.
- Passthrough/pipelining: back-to-back ALU ops with RDM=5,6,7, PCPlus4M=0x104,0x108,0x10C, ResultSrcM=0 -> the W outputs follow one cycle later with ResultSrcW=0 and MisalignW=0.
- Wrap and reset-mid-store: SW 0xCAFEF00D @(DEPTH*4+0x8) -> LW @0x8 returns 0xCAFEF00D. SW @0x8 asserted with rst=0 -> memory unchanged.
